// File: rtl/divider_pkg.sv
// divider_pkg: operand widths, iteration count and FSM states shared by the restoring divider
package divider_pkg;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W = 4;
  localparam int ITER_N = 8;
  localparam int CNT_W = $clog2(ITER_N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring iteration (r_in, bit_in, divisor -> r_out = shifted partial remainder less divisor when it fits, q_bit)
module div_step
  import divider_pkg::*;
(
  input  logic [DIVISOR_W-1:0] r_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 q_bit
);
  logic [DIVISOR_W:0] sh;
  assign sh = {r_in, bit_in};
  assign q_bit = sh >= {1'b0, divisor};
  assign r_out = q_bit ? DIVISOR_W'(sh - {1'b0, divisor}) : sh[DIVISOR_W-1:0];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: 8/4 restoring divider (clk, rst_n, start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero); DIVIDER_ZERO_FAST_EN finishes divide-by-zero one cycle after accept
module restoring_divider
  import divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [DIVIDEND_W-1:0] dq;
  logic [DIVISOR_W-1:0] dvs, r, r_next;
  logic q_bit, fast;
`ifdef DIVIDER_ZERO_FAST_EN
  assign fast = divisor == '0;
`else
  assign fast = 1'b0;
`endif
  div_step u_step (
    .r_in   (r),
    .bit_in (dq[DIVIDEND_W-1]),
    .divisor(dvs),
    .r_out  (r_next),
    .q_bit  (q_bit)
  );
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (start ? (fast ? DONE : RUN) : IDLE)
            : state == RUN  ? (cnt == '0 ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // dq shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      dq <= '0;
      dvs <= '0;
      r <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt <= CNT_W'(ITER_N - 1);
      dq <= dividend;
      dvs <= divisor;
      r <= '0;
      if (fast) begin
        quotient <= '1;
        remainder <= dividend[DIVISOR_W-1:0];
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt <= cnt - CNT_W'(1);
      dq <= {dq[DIVIDEND_W-2:0], q_bit};
      r <= r_next;
      if (cnt == '0) begin
        quotient <= {dq[DIVIDEND_W-2:0], q_bit};
        remainder <= r_next;
        div_by_zero <= dvs == '0;
      end
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and exhaustive self-checking bench for restoring_divider
module tb_restoring_divider;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, div_by_zero;
  logic [7:0] dividend, quotient;
  logic [3:0] divisor, remainder;
  int total = 0, bad = 0, zlat;
  always #5 clk = ~clk;
  restoring_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez, input int el);
    int lat = 1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, el);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_by_zero, ez);
    @(posedge clk);
    #1 check({tag, "_idle"}, {busy, done}, 2'b00);
    check({tag, "_hold"}, quotient, eq);
  endtask
  initial begin
    int ndone, first;
    logic [7:0] a, eq;
    logic [3:0] b, er;
`ifdef DIVIDER_ZERO_FAST_EN
    zlat = 1;
`else
    zlat = 9;
`endif
    rst_n = 1'b0;
    start = 1'b1;
    dividend = 8'd200;
    divisor = 4'd7;
    repeat (3) @(posedge clk);
    #1 check("reset_out", {busy, done, quotient, remainder, div_by_zero}, 15'h0);
    rst_n = 1'b1;
    start = 1'b0;
    run_div("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9);
    run_div("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);
    run_div("d15_15", 8'd15, 4'd15, 8'd1, 4'd0, 1'b0, 9);
    run_div("d173_0", 8'd173, 4'd0, 8'hFF, 4'hD, 1'b1, zlat);
    run_div("d0_5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 9);
    run_div("d0_0", 8'd0, 4'd0, 8'hFF, 4'd0, 1'b1, zlat);
    run_div("d100_3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9);
    run_div("d9_10", 8'd9, 4'd10, 8'd0, 4'd9, 1'b0, 9);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    first = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
      if (c == 3) begin
        start = 1'b1;
        dividend = 8'd50;
        divisor = 4'd3;
      end
      if (c == 4) start = 1'b0;
      @(posedge clk);
      #1;
    end
    check("ign_ndone", ndone, 1);
    check("ign_lat", first, 9);
    check("ign_q", quotient, 8'd28);
    check("ign_r", remainder, 4'd4);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    start = 1'b0;
    check("abort_out", {busy, done, quotient, remainder, div_by_zero}, 15'h0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 if (done || busy) ndone++;
    end
    check("abort_quiet", ndone, 0);
    run_div("after_abort", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9);
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 8'(i);
        b = 4'(j);
        eq = j == 0 ? 8'hFF : 8'(i / j);
        er = j == 0 ? a[3:0] : 4'(i % j);
        run_div("sweep", a, b, eq, er, j == 0, j == 0 ? zlat : 9);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
